dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//  Data-memory stage: consumes the core's MEM-stage access (MemWriteM, ALUOutM, WriteDataM) and returns ReadDataM.
//  Word RAM plus a small MMIO window: byte TX FIFO (valid/ready drain), 32-bit cycle counter, status register.
//  Reads are combinational, so the core's single-cycle MEM stage needs no stall. Writes commit on the clk rising edge.
// PARAMETERS
//  DEPTH      64             RAM size in 32-bit words; power of 2, >=4
//  FIFO_DEPTH 8              TX FIFO entries (8-bit); power of 2, >=2
//  MMIO_BASE  32'hFFFF_FF00  base of 256-byte MMIO window; addr[31:8]==MMIO_BASE[31:8] selects MMIO
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset (0 = in reset)
//  MemWriteM   in   1   write strobe, MEM stage
//  ALUOutM     in   32  byte address
//  WriteDataM  in   32  write data
//  ReadDataM   out  32  read data, combinational from ALUOutM
//  tx_valid    out  1   FIFO head valid
//  tx_data     out  8   FIFO head byte
//  tx_ready    in   1   consumer accepts head when tx_valid&tx_ready at clk edge
//  align_err   out  1   sticky misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  Decode: MMIO if addr[31:8]==MMIO_BASE[31:8], else RAM; RAM index = addr[log2(DEPTH)+1:2] (upper bits alias/wrap).
//  RAM: no reset of contents; write when MemWriteM & RAM-hit at edge; read-during-write returns old word.
//  MMIO offsets (addr[7:0]); unlisted offsets read 0, writes ignored:
//   0x00 TXDATA  W: push WriteDataM[7:0]; R: 0
//   0x04 STATUS  R: {22'b0, align_err, ovf, full, empty, cnt[5:0]}; W: bit9=1 clears ovf
//   0x08 CYCLE   R: counter; W: counter<=0 (write beats increment that cycle)
//  Cycle counter: +1 every cycle out of reset, wraps 0xFFFF_FFFF->0.
//  FIFO: cnt 0..FIFO_DEPTH, wrap-around rd/wr pointers; tx_valid=(cnt!=0); tx_data=entry[rd_ptr].
//   push visible on tx_valid the cycle after the write edge (1-cycle latency).
//   pop on tx_valid&tx_ready; tx_ready while empty ignored.
//   push when full and no pop: byte dropped, ovf<=1 (sticky until STATUS bit9 write or reset).
//   push+pop same cycle: both succeed incl. when full (cnt unchanged, no ovf); when empty only push occurs.
//   tx_data stable while tx_valid & !tx_ready.
//  Reset (async, any time incl. mid-drain): cnt=0, ptrs=0, ovf=0, counter=0, align_err=0;
//   tx_valid=0, tx_data=0 immediately; ReadDataM follows decode (RAM unchanged).
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: access with addr[1:0]!=0 while MemWriteM=1 is dropped (no RAM/MMIO side effect);
//   any such write, or a read decode with addr[1:0]!=0 when MemWriteM=0 and addr in MMIO, sets align_err sticky;
//   cleared only by reset. STATUS bit9 reflects it.
//  Not defined: addr[1:0] ignored (word access to addr&~3); align_err tied 0; STATUS bit9 reads 0.
// TESTING
//  1 write 0x1234_5678 @0x10, then read 0x10 -> ReadDataM=0x1234_5678; read @0x10+DEPTH*4 -> same (alias).
//  2 write 0x41,0x42 to TXDATA, tx_ready=0 -> tx_valid=1,tx_data=0x41, STATUS cnt=2; tx_ready=1 2 cycles -> 0x41,0x42 then empty.
//  3 9 pushes with tx_ready=0, FIFO_DEPTH=8 -> full=1, ovf=1, 9th byte absent; write STATUS 0x200 -> ovf=0.
//  4 full FIFO, push 0x55 with tx_ready=1 same cycle -> cnt stays 8, ovf=0, 0x55 drained last.
//  5 write CYCLE, read 3 cycles later -> 3; force counter 0xFFFF_FFFF -> next read 0.
//  6 reset low mid-drain with cnt=5 -> tx_valid=0 immediately, cnt=0; macro on: write @0x11 -> RAM unchanged, align_err=1.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus MMIO window (TX byte FIFO, cycle counter, status).
// Optional feature macro: DMEM_ALIGN_CHECK_EN (drop misaligned writes, sticky align_err).
module dmem_mmio #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        align_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = FW + 1;

    localparam logic [5:0] OFF_TXDATA = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_CYCLE  = 6'h02;

    logic [31:0]   ram_q [DEPTH];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [FW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;

    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [5:0]    mmio_word;
    logic          wr_ok;
    logic          push_req, status_wr, cycle_wr;
    logic          full, pop, do_push;
    logic [31:0]   status_word;

    assign mmio_hit  = (ALUOutM[31:8] == MMIO_BASE[31:8]);
    assign ram_idx   = ALUOutM[AW+1:2];
    assign mmio_word = ALUOutM[7:2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic misaligned;
    logic align_err_q, align_err_d;

    assign misaligned  = (ALUOutM[1:0] != 2'b00);
    assign wr_ok       = MemWriteM & ~misaligned;
    // Reads only flag when they decode into MMIO; writes flag anywhere.
    assign align_err_d = align_err_q | (misaligned & (MemWriteM | mmio_hit));
    assign align_err   = align_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    logic [1:0] unused_addr_lo;

    assign unused_addr_lo = ALUOutM[1:0];
    assign wr_ok          = MemWriteM;
    assign align_err      = 1'b0;
`endif

    assign push_req  = wr_ok & mmio_hit & (mmio_word == OFF_TXDATA);
    assign status_wr = wr_ok & mmio_hit & (mmio_word == OFF_STATUS);
    assign cycle_wr  = wr_ok & mmio_hit & (mmio_word == OFF_CYCLE);

    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign tx_valid = (cnt_q != '0);
    assign pop      = tx_valid & tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push_req & (~full | pop);
    assign tx_data  = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + FW'(1);
        end
        case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (status_wr && WriteDataM[9]) begin
            ovf_d = 1'b0;
        end
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        cycle_d = cycle_wr ? '0 : cycle_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !mmio_hit) begin
            ram_q[ram_idx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_q[wr_ptr_q] <= WriteDataM[7:0];
        end
    end

    always_comb begin
        status_word      = '0;
        status_word[5:0] = 6'(cnt_q);
        status_word[6]   = ~tx_valid;
        status_word[7]   = full;
        status_word[8]   = ovf_q;
        status_word[9]   = align_err;
    end

    always_comb begin
        ReadDataM = '0;
        if (mmio_hit) begin
            case (mmio_word)
                OFF_STATUS: ReadDataM = status_word;
                OFF_CYCLE:  ReadDataM = cycle_q;
                default:    ReadDataM = '0;
            endcase
        end else begin
            ReadDataM = ram_q[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: vector table for RAM/FIFO basics, hand sequences for corner cases.
module tb_dmem_mmio;

    localparam logic [31:0] TXA = 32'hFFFF_FF00;
    localparam logic [31:0] STA = 32'hFFFF_FF04;
    localparam logic [31:0] CYA = 32'hFFFF_FF08;
    localparam logic [31:0] UNA = 32'hFFFF_FF20;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        align_err;

    int nchecks = 0;
    int nerr    = 0;

    dmem_mmio #(
        .DEPTH      (64),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (32'hFFFF_FF00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .align_err  (align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        @(negedge clk);
        MemWriteM  = we;
        ALUOutM    = addr;
        WriteDataM = wd;
        tx_ready   = rdy;
        #1;
    endtask

    initial begin
        logic [7:0] drain4 [8];

        //           we    addr          wdata          rdy   chk   exp_rd         vld   data
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
        vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, TXA,           32'h0000_0141, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
        vecs[6]  = '{1'b1, TXA,           32'h0000_0042, 1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
        vecs[7]  = '{1'b0, STA,           32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 8'h41};
        vecs[8]  = '{1'b0, STA,           32'h0,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 8'h41};
        vecs[9]  = '{1'b0, STA,           32'h0,         1'b1, 1'b1, 32'h0000_0001, 1'b1, 8'h42};
        vecs[10] = '{1'b0, STA,           32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b0, 8'h00};
        vecs[11] = '{1'b1, UNA,           32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
        vecs[12] = '{1'b0, STA,           32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b0, 8'h00};

        drain4 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};

        reset      = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = STA;
        WriteDataM = '0;
        tx_ready   = 1'b0;
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        check("rst_status", ReadDataM, 32'h0000_0040);
        ALUOutM = CYA;
        #1;
        check("rst_cycle", ReadDataM, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), ReadDataM, vecs[i].exp_rd);
            check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
        end

        // Overflow: ninth push dropped, ovf sticky until STATUS bit9 write.
        for (int i = 1; i <= 9; i++) step(1'b1, TXA, 32'(i), 1'b0);
        step(1'b0, STA, 32'h0, 1'b0);
        check("ovf_status", ReadDataM, 32'h0000_0188);
        check("ovf_head", 32'(tx_data), 32'h01);
        step(1'b1, STA, 32'h0000_0200, 1'b0);
        step(1'b0, STA, 32'h0, 1'b0);
        check("ovf_cleared", ReadDataM, 32'h0000_0088);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, STA, 32'h0, 1'b1);
            check($sformatf("ovf_drain%0d", k), 32'(tx_data), 32'(k));
        end
        step(1'b0, STA, 32'h0, 1'b0);
        check("ovf_empty_valid", 32'(tx_valid), 32'd0);
        check("ovf_empty_status", ReadDataM, 32'h0000_0040);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, TXA, 32'h10 + 32'(i), 1'b0);
        step(1'b1, TXA, 32'h55, 1'b1);
        check("fullpp_head", 32'(tx_data), 32'h10);
        step(1'b0, STA, 32'h0, 1'b0);
        check("fullpp_status", ReadDataM, 32'h0000_0088);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, STA, 32'h0, 1'b1);
            check($sformatf("fullpp_drain%0d", k), 32'(tx_data), 32'(drain4[k]));
        end
        step(1'b0, STA, 32'h0, 1'b0);
        check("fullpp_empty", ReadDataM, 32'h0000_0040);

        // Cycle counter clear and wrap.
        step(1'b1, CYA, 32'h0, 1'b0);
        step(1'b0, CYA, 32'h0, 1'b0);
        check("cycle_clear", ReadDataM, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("cycle_plus3", ReadDataM, 32'd3);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        #1;
        check("cycle_max", ReadDataM, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check("cycle_wrap", ReadDataM, 32'd0);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 7; i++) step(1'b1, TXA, 32'h61 + 32'(i), 1'b0);
        step(1'b0, STA, 32'h0, 1'b1);
        step(1'b0, STA, 32'h0, 1'b1);
        step(1'b0, STA, 32'h0, 1'b0);
        check("mid_status", ReadDataM, 32'h0000_0005);
        check("mid_head", 32'(tx_data), 32'h63);
        tx_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(tx_valid), 32'd0);
        check("arst_data", 32'(tx_data), 32'd0);
        check("arst_status", ReadDataM, 32'h0000_0040);
        ALUOutM = 32'h0000_0010;
        #1;
        check("arst_ram_kept", ReadDataM, 32'h1234_5678);
        @(negedge clk);
        reset    = 1'b1;
        tx_ready = 1'b0;

`ifdef DMEM_ALIGN_CHECK_EN
        step(1'b1, 32'h0000_0011, 32'hAAAA_AAAA, 1'b0);
        step(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("align_ram_unchanged", ReadDataM, 32'h1234_5678);
        check("align_err_set", 32'(align_err), 32'd1);
        step(1'b0, STA, 32'h0, 1'b0);
        check("align_status", ReadDataM, 32'h0000_0240);
`else
        step(1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b0);
        step(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("noalign_word_write", ReadDataM, 32'hCAFE_F00D);
        check("noalign_err_low", 32'(align_err), 32'd0);
        step(1'b0, STA, 32'h0, 1'b0);
        check("noalign_status", ReadDataM, 32'h0000_0040);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
